pll_hdmi_cfg_seq: RTL and testbench
===================================

# pll_hdmi_cfg_seq

Reconfiguration sequencer for the HDMI pixel-clock PLL. It accepts a complete PLL setting in one request and writes it into the PLL reconfiguration controller over its Avalon-MM management port (mode, N, M, C0, K, bandwidth, charge pump, start). It then waits for the PLL to relock and reports done or timeout. It sits between the video-mode/scaler control logic and the reconfig controller that drives `reconfig_to_pll` of the HDMI PLL.

## Interface
Parameters:
- `LOCK_TIMEOUT`, 24'd5_000_000 — cycles allowed for relock after START completes
- `LOCK_STABLE`, 256 — consecutive synchronized `locked`-high cycles required to declare lock

Ports:
- `clk` in 1 — management clock; sequencer and Avalon master run on it
- `rst` in 1 — asynchronous, active-high reset
- `cfg_req` in 1 — single-cycle request; accepted only when `busy`=0
- `cfg_m_hi`, `cfg_m_lo` in 8 each — M counter high/low counts
- `cfg_n_hi`, `cfg_n_lo` in 8 each — N counter counts
- `cfg_n_bypass` in 1 — N bypass
- `cfg_c0_hi`, `cfg_c0_lo` in 8 each — C0 counts
- `cfg_c0_odd` in 1 — C0 odd-divide duty correction
- `cfg_k` in 32 — fractional division value
- `cfg_bw` in 4 — bandwidth setting
- `cfg_cp` in 3 — charge-pump setting
- `busy` out 1 — a request is in progress
- `cfg_done` out 1 — one-cycle pulse on successful completion
- `cfg_err` out 1 — sticky timeout flag; cleared on next accepted request
- `mgmt_address` out 6 — Avalon address
- `mgmt_write` out 1 — Avalon write strobe
- `mgmt_writedata` out 32 — Avalon write data
- `mgmt_waitrequest` in 1 — Avalon stall
- `pll_locked` in 1 — PLL lock, asynchronous to `clk`

## Operation
- All `cfg_*` fields are registered on the accept cycle. Later changes to the inputs do not affect the sequence in progress.
- `cfg_req` while `busy`=1 is ignored, with no queueing.
- States: IDLE → WRITE (steps 0..7) → WAIT_UNLOCK → WAIT_LOCK → IDLE.
- Write steps, as address:data:
  - 0x00: 0 — waitrequest mode
  - 0x03: N word
  - 0x04: M word
  - 0x05: C0 word
  - 0x07: K
  - 0x08: {28'b0, bw}
  - 0x09: {29'b0, cp}
  - 0x02: 1 — START
- Counter word: bits[7:0] = lo, bits[15:8] = hi, bit16 = bypass, bit17 = odd, bits[22:18] = counter select (0 for C0). For M, bypass and odd are 0.
- Each write completes on the first cycle with `mgmt_write`=1 and `mgmt_waitrequest`=0. The next step's address/data are presented in the following cycle, with `mgmt_write` continuously high across steps.
- After START is accepted, the sequencer goes to WAIT_UNLOCK. It stays there until synchronized lock = 0, or for at most 16 cycles, then goes to WAIT_LOCK.
- WAIT_LOCK:
  - Stability counter increments while synchronized lock = 1 and resets to 0 when lock = 0. Reaching `LOCK_STABLE` gives `cfg_done` pulse → IDLE.
  - Timeout counter reaching `LOCK_TIMEOUT` sets `cfg_err` → IDLE, with no `cfg_done`.
  - If both happen in the same cycle, success wins.
- `pll_locked` passes through a 2-flop synchronizer before any use.
- `rst` mid-operation returns to IDLE immediately and drops `mgmt_write`. The system guarantees `rst` also resets the reconfig controller.

## Timing
- Reset values:
  - `busy`, `cfg_done`, `cfg_err`, `mgmt_write` = 0
  - `mgmt_address` = 0, `mgmt_writedata` = 0
  - state = IDLE, counters = 0
- `busy` rises the cycle after `cfg_req` is accepted. `mgmt_write` rises in that same cycle.
- With zero waitrequest, the 8 writes occupy exactly 8 consecutive cycles.
- `busy` falls in the same cycle that `cfg_done` pulses or `cfg_err` sets.
- A new `cfg_req` is accepted earliest on the cycle after `busy` falls.
- Synchronizer adds 2 cycles of lock latency. Minimum done latency from accept = 8 + 1 (unlock check) + 2 + `LOCK_STABLE` cycles.
- Counter widths: timeout 24 bits; stability `$clog2(LOCK_STABLE+1)`; unlock wait 5 bits. No wrap: counters saturate and stop at their terminal value.

## Structure
- Package `pll_cfg_pkg`:
  - register address constants (MODE, STATUS, START, N, M, C, K, BW, CP)
  - bit-field positions of the counter word
  - state enum
  - function `pll_cnt_word(hi, lo, bypass, odd, sel)`
- One sub-module: `sync2`, the lock synchronizer.
- Write step data comes from a case on the step index over the registered config, not a separate ROM module.

## Test plan
- 148.5 MHz set: M 4/4, N bypass, C0 2/1 odd, K 3908420153, bw 6, cp 1, zero waitrequest, lock drops then returns. Required: writes (0x00,0), (0x03,0x00010000), (0x04,0x00000404), (0x05,0x00020201), (0x07,0xE8F5C239), (0x08,6), (0x09,1), (0x02,1) on consecutive cycles, then `cfg_done` after `LOCK_STABLE` stable cycles.
- Waitrequest held 5 cycles on the N write and 40 cycles on START → address/data held stable, no step skipped or repeated.
- `pll_locked` never returns, `LOCK_TIMEOUT`=1000 → `cfg_err`=1 and `busy`=0 exactly 1000 cycles into WAIT_LOCK, no `cfg_done`. Next `cfg_req` clears `cfg_err`.
- Lock glitches low once at stability count 200 of 256 → count restarts, done arrives 256 cycles after the glitch.
- `cfg_req` while `busy`, with changed `cfg_k` → ignored; the data written is the originally latched K.
- `rst` asserted during the M write → `mgmt_write`=0 and `busy`=0 immediately. A fresh request afterwards runs the full 8-write sequence from step 0.

Source files
------------

// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the HDMI PLL reconfiguration sequencer:
// register map, counter-word layout, FSM states and config bundle.
package pll_cfg_pkg;

    // Reconfig controller register addresses
    localparam logic [5:0] ADDR_MODE   = 6'h00;
    localparam logic [5:0] ADDR_STATUS = 6'h01;
    localparam logic [5:0] ADDR_START  = 6'h02;
    localparam logic [5:0] ADDR_N      = 6'h03;
    localparam logic [5:0] ADDR_M      = 6'h04;
    localparam logic [5:0] ADDR_C      = 6'h05;
    localparam logic [5:0] ADDR_K      = 6'h07;
    localparam logic [5:0] ADDR_BW     = 6'h08;
    localparam logic [5:0] ADDR_CP     = 6'h09;

    // Counter word layout
    localparam int CW_LO_LSB  = 0;
    localparam int CW_HI_LSB  = 8;
    localparam int CW_BYP_BIT = 16;
    localparam int CW_ODD_BIT = 17;
    localparam int CW_SEL_LSB = 18;

    localparam logic [4:0]  SEL_NONE     = 5'd0;
    localparam logic [4:0]  SEL_C0       = 5'd0;
    localparam logic [31:0] MODE_WAITREQ = 32'd0;
    localparam logic [31:0] START_GO     = 32'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WAIT_UNLOCK,
        ST_WAIT_LOCK
    } state_e;

    typedef struct packed {
        logic [7:0]  m_hi;
        logic [7:0]  m_lo;
        logic [7:0]  n_hi;
        logic [7:0]  n_lo;
        logic        n_bypass;
        logic [7:0]  c0_hi;
        logic [7:0]  c0_lo;
        logic        c0_odd;
        logic [31:0] k;
        logic [3:0]  bw;
        logic [2:0]  cp;
    } pll_cfg_t;

    function automatic logic [31:0] pll_cnt_word(
        input logic [7:0] hi,
        input logic [7:0] lo,
        input logic       bypass,
        input logic       odd,
        input logic [4:0] sel
    );
        logic [31:0] w;
        w = '0;
        w[CW_LO_LSB +: 8]  = lo;
        w[CW_HI_LSB +: 8]  = hi;
        w[CW_BYP_BIT]      = bypass;
        w[CW_ODD_BIT]      = odd;
        w[CW_SEL_LSB +: 5] = sel;
        return w;
    endfunction

endpackage

// File: rtl/pll_hdmi_cfg_seq_if.sv
// Avalon-MM management port between the sequencer (master) and the
// PLL reconfig controller (slave): address, write, writedata, waitrequest.
interface pll_hdmi_cfg_seq_if;

    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest;

    modport master (
        output mgmt_address,
        output mgmt_write,
        output mgmt_writedata,
        input  mgmt_waitrequest
    );

    modport slave (
        input  mgmt_address,
        input  mgmt_write,
        input  mgmt_writedata,
        output mgmt_waitrequest
    );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for the asynchronous PLL lock signal.
// Ports: clk, rst (async high), d_i (async in), q_o (synchronized out).
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/pll_hdmi_cfg_seq.sv
// HDMI PLL reconfiguration sequencer: latches a full PLL setting, writes
// it over Avalon-MM (mode, N, M, C0, K, BW, CP, START), then waits for
// relock and reports cfg_done or a sticky cfg_err on timeout.
// Ports: clk/rst, cfg_req + cfg_* setting, busy/cfg_done/cfg_err status,
// mgmt (Avalon master modport), pll_locked (asynchronous).
module pll_hdmi_cfg_seq
    import pll_cfg_pkg::*;
#(
    parameter logic [23:0] LOCK_TIMEOUT = 24'd5_000_000,
    parameter int          LOCK_STABLE  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_req,
    input  logic [7:0]  cfg_m_hi,
    input  logic [7:0]  cfg_m_lo,
    input  logic [7:0]  cfg_n_hi,
    input  logic [7:0]  cfg_n_lo,
    input  logic        cfg_n_bypass,
    input  logic [7:0]  cfg_c0_hi,
    input  logic [7:0]  cfg_c0_lo,
    input  logic        cfg_c0_odd,
    input  logic [31:0] cfg_k,
    input  logic [3:0]  cfg_bw,
    input  logic [2:0]  cfg_cp,
    output logic        busy,
    output logic        cfg_done,
    output logic        cfg_err,
    pll_hdmi_cfg_seq_if.master mgmt,
    input  logic        pll_locked
);

    localparam int          SW         = $clog2(LOCK_STABLE + 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(LOCK_STABLE);
    localparam logic [4:0]  UNLOCK_MAX = 5'd15;

    state_e        state_q, state_d;
    pll_cfg_t      cfg_q, cfg_d;
    logic [2:0]    step_q, step_d;
    logic [4:0]    unl_q, unl_d;
    logic [SW-1:0] stab_q, stab_d, stab_inc;
    logic [23:0]   tmo_q, tmo_d, tmo_inc;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          lock_s;
    logic [5:0]    addr;
    logic [31:0]   wdata;

    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d_i (pll_locked),
        .q_o (lock_s)
    );

    // step_q is 0 outside WRITE, so address/data idle at 0
    always_comb begin
        addr  = ADDR_MODE;
        wdata = MODE_WAITREQ;
        unique case (step_q)
            3'd0: begin
                addr  = ADDR_MODE;
                wdata = MODE_WAITREQ;
            end
            3'd1: begin
                addr  = ADDR_N;
                wdata = pll_cnt_word(cfg_q.n_hi, cfg_q.n_lo,
                                     cfg_q.n_bypass, 1'b0, SEL_NONE);
            end
            3'd2: begin
                addr  = ADDR_M;
                wdata = pll_cnt_word(cfg_q.m_hi, cfg_q.m_lo,
                                     1'b0, 1'b0, SEL_NONE);
            end
            3'd3: begin
                addr  = ADDR_C;
                wdata = pll_cnt_word(cfg_q.c0_hi, cfg_q.c0_lo,
                                     1'b0, cfg_q.c0_odd, SEL_C0);
            end
            3'd4: begin
                addr  = ADDR_K;
                wdata = cfg_q.k;
            end
            3'd5: begin
                addr  = ADDR_BW;
                wdata = {28'b0, cfg_q.bw};
            end
            3'd6: begin
                addr  = ADDR_CP;
                wdata = {29'b0, cfg_q.cp};
            end
            3'd7: begin
                addr  = ADDR_START;
                wdata = START_GO;
            end
            default: ;
        endcase
    end

    // Saturating increments
    assign stab_inc = (stab_q == STABLE_MAX) ? stab_q : stab_q + SW'(1);
    assign tmo_inc  = (tmo_q == LOCK_TIMEOUT) ? tmo_q : tmo_q + 24'd1;

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        step_d  = step_q;
        unl_d   = unl_q;
        stab_d  = stab_q;
        tmo_d   = tmo_q;
        done_d  = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_req) begin
                    cfg_d.m_hi     = cfg_m_hi;
                    cfg_d.m_lo     = cfg_m_lo;
                    cfg_d.n_hi     = cfg_n_hi;
                    cfg_d.n_lo     = cfg_n_lo;
                    cfg_d.n_bypass = cfg_n_bypass;
                    cfg_d.c0_hi    = cfg_c0_hi;
                    cfg_d.c0_lo    = cfg_c0_lo;
                    cfg_d.c0_odd   = cfg_c0_odd;
                    cfg_d.k        = cfg_k;
                    cfg_d.bw       = cfg_bw;
                    cfg_d.cp       = cfg_cp;
                    err_d          = 1'b0;
                    step_d         = 3'd0;
                    state_d        = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!mgmt.mgmt_waitrequest) begin
                    if (step_q == 3'd7) begin
                        step_d  = 3'd0;
                        unl_d   = 5'd0;
                        state_d = ST_WAIT_UNLOCK;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            ST_WAIT_UNLOCK: begin
                // A PLL that never visibly drops lock must not stall us
                if (!lock_s || unl_q == UNLOCK_MAX) begin
                    stab_d  = '0;
                    tmo_d   = '0;
                    state_d = ST_WAIT_LOCK;
                end else begin
                    unl_d = unl_q + 5'd1;
                end
            end
            ST_WAIT_LOCK: begin
                stab_d = lock_s ? stab_inc : '0;
                tmo_d  = tmo_inc;
                // Lock success takes priority over a coincident timeout
                if (lock_s && stab_inc == STABLE_MAX) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (tmo_inc == LOCK_TIMEOUT) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cfg_q   <= '0;
            step_q  <= 3'd0;
            unl_q   <= 5'd0;
            stab_q  <= '0;
            tmo_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            step_q  <= step_d;
            unl_q   <= unl_d;
            stab_q  <= stab_d;
            tmo_q   <= tmo_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy                = (state_q != ST_IDLE);
    assign cfg_done            = done_q;
    assign cfg_err             = err_q;
    assign mgmt.mgmt_write     = (state_q == ST_WRITE);
    assign mgmt.mgmt_address   = addr;
    assign mgmt.mgmt_writedata = wdata;

endmodule

// File: tb/tb_pll_hdmi_cfg_seq.sv
// Scoreboard bench for pll_hdmi_cfg_seq: random settings, stalls and lock
// traces; expected writes and completion cycles come from a trace model.
module tb_pll_hdmi_cfg_seq;

    localparam int TMO = 1000;
    localparam int STB = 256;
    localparam int NONE = -1000;

    typedef struct {
        bit [7:0]  mh, ml, nh, nl;
        bit        nb;
        bit [7:0]  ch, cl;
        bit        co;
        bit [31:0] k;
        bit [3:0]  bw;
        bit [2:0]  cp;
    } cfg_t;

    typedef struct {
        bit [5:0]  a;
        bit [31:0] d;
        int        edge_n;
    } wr_t;

    typedef struct {
        bit err;
        int edge_n;
    } cpl_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_req = 1'b0;
    logic [7:0]  cfg_m_hi = 0, cfg_m_lo = 0, cfg_n_hi = 0, cfg_n_lo = 0;
    logic        cfg_n_bypass = 0;
    logic [7:0]  cfg_c0_hi = 0, cfg_c0_lo = 0;
    logic        cfg_c0_odd = 0;
    logic [31:0] cfg_k = 0;
    logic [3:0]  cfg_bw = 0;
    logic [2:0]  cfg_cp = 0;
    logic        busy, cfg_done, cfg_err;
    logic        pll_locked = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    wr_t  wq[$];
    cpl_t cq[$];
    int stall[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int widx = 0, wcnt = 0;
    int addr_tab[8] = '{0, 3, 4, 5, 7, 8, 9, 2};
    int sbase = 0, s_lo = 0, s_hi = 0, s_gl = NONE;
    bit s_nev = 0;
    bit err_prev = 0;

    pll_hdmi_cfg_seq_if mg();

    pll_hdmi_cfg_seq #(
        .LOCK_TIMEOUT (24'd1000),
        .LOCK_STABLE  (STB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_req      (cfg_req),
        .cfg_m_hi     (cfg_m_hi),
        .cfg_m_lo     (cfg_m_lo),
        .cfg_n_hi     (cfg_n_hi),
        .cfg_n_lo     (cfg_n_lo),
        .cfg_n_bypass (cfg_n_bypass),
        .cfg_c0_hi    (cfg_c0_hi),
        .cfg_c0_lo    (cfg_c0_lo),
        .cfg_c0_odd   (cfg_c0_odd),
        .cfg_k        (cfg_k),
        .cfg_bw       (cfg_bw),
        .cfg_cp       (cfg_cp),
        .busy         (busy),
        .cfg_done     (cfg_done),
        .cfg_err      (cfg_err),
        .mgmt         (mg),
        .pll_locked   (pll_locked)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Raw lock level sampled by the DUT at edge e
    function automatic bit lockv(input int e);
        int r;
        r = e - sbase;
        if (s_nev && r >= s_lo) return 1'b0;
        if (r >= s_lo && r < s_hi) return 1'b0;
        if (r == s_gl) return 1'b0;
        return 1'b1;
    endfunction

    // Completion model: after START (edge es) wait for a seen drop or 16
    // cycles, then scan the synchronized trace for STB consecutive highs
    // within TMO cycles. The synchronizer means edge e sees lockv(e-2).
    function automatic cpl_t model_cpl(input int es);
        int e, k, run, t;
        cpl_t c;
        e = es; k = 0; run = 0; t = 0;
        while (1) begin
            e++;
            if (!lockv(e - 2) || k == 15) break;
            k++;
        end
        while (1) begin
            e++;
            t++;
            run = lockv(e - 2) ? run + 1 : 0;
            if (run == STB) begin
                c.err = 0; c.edge_n = e; return c;
            end
            if (t == TMO) begin
                c.err = 1; c.edge_n = e; return c;
            end
        end
    endfunction

    function automatic bit [31:0] cword(input bit [7:0] hi, input bit [7:0] lo,
                                        input bit byp, input bit odd);
        return 32'(lo) + 32'(hi) * 256 + 32'(byp) * 65536 + 32'(odd) * 131072;
    endfunction

    function automatic bit [31:0] exp_data(input cfg_t c, input int i);
        case (i)
            1: return cword(c.nh, c.nl, c.nb, 1'b0);
            2: return cword(c.mh, c.ml, 1'b0, 1'b0);
            3: return cword(c.ch, c.cl, 1'b0, c.co);
            4: return c.k;
            5: return 32'(c.bw);
            6: return 32'(c.cp);
            7: return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c.mh = 8'($urandom); c.ml = 8'($urandom);
        c.nh = 8'($urandom); c.nl = 8'($urandom);
        c.nb = 1'($urandom);
        c.ch = 8'($urandom); c.cl = 8'($urandom);
        c.co = 1'($urandom);
        c.k  = $urandom;
        c.bw = 4'($urandom); c.cp = 3'($urandom);
        return c;
    endfunction

    task automatic drive(input cfg_t c);
        cfg_m_hi = c.mh; cfg_m_lo = c.ml;
        cfg_n_hi = c.nh; cfg_n_lo = c.nl; cfg_n_bypass = c.nb;
        cfg_c0_hi = c.ch; cfg_c0_lo = c.cl; cfg_c0_odd = c.co;
        cfg_k = c.k; cfg_bw = c.bw; cfg_cp = c.cp;
    endtask

    // Avalon slave: stalls step i for stall[i] cycles
    initial forever begin
        @(negedge clk);
        if (rst || !mg.mgmt_write) begin
            mg.mgmt_waitrequest = 1'b0;
        end else if (wcnt < ((widx < 8) ? stall[widx] : 0)) begin
            mg.mgmt_waitrequest = 1'b1;
            wcnt++;
        end else begin
            mg.mgmt_waitrequest = 1'b0;
            widx++;
            wcnt = 0;
        end
    end

    initial mg.mgmt_waitrequest = 1'b0;

    // Lock driver: value sampled at the next edge
    initial forever begin
        @(negedge clk);
        pll_locked = lockv(cyc + 1);
    end

    // Monitor: writes complete at the coming edge; completions at the last
    initial forever begin
        wr_t  w;
        cpl_t c;
        @(negedge clk);
        #1;
        if (!rst) begin
            if (mg.mgmt_write) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                             mg.mgmt_address, mg.mgmt_writedata);
                end else if (mg.mgmt_waitrequest) begin
                    chk("hold_addr", mg.mgmt_address, wq[0].a);
                    chk("hold_data", mg.mgmt_writedata, wq[0].d);
                end else begin
                    w = wq.pop_front();
                    chk("wr_addr", mg.mgmt_address, w.a);
                    chk("wr_data", mg.mgmt_writedata, w.d);
                    chk("wr_edge", cyc + 1, w.edge_n);
                end
            end
            if (cfg_done || (cfg_err && !err_prev)) begin
                if (cq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cpl: done %0b err %0b, none expected",
                             cfg_done, cfg_err);
                end else begin
                    c = cq.pop_front();
                    chk("cpl_is_err", cfg_done ? 1'b0 : 1'b1, c.err);
                    chk("cpl_edge", cyc, c.edge_n);
                    chk("cpl_busy_low", busy, 1'b0);
                end
            end
        end
        err_prev = cfg_err;
    end

    task automatic start_txn(input cfg_t c, input int st[8], input int lo,
                             input int hi, input int gl, input bit nev);
        int acc;
        wr_t w;
        @(negedge clk);
        #3;
        drive(c);
        cfg_req = 1'b1;
        for (int i = 0; i < 8; i++) stall[i] = st[i];
        widx = 0;
        wcnt = 0;
        acc = cyc + 1;
        for (int i = 0; i < 8; i++) begin
            acc += 1 + st[i];
            w.a = 6'(addr_tab[i]);
            w.d = exp_data(c, i);
            w.edge_n = acc;
            wq.push_back(w);
        end
        sbase = acc; s_lo = lo; s_hi = hi; s_gl = gl; s_nev = nev;
        cq.push_back(model_cpl(acc));
        @(negedge clk);
        #3;
        cfg_req = 1'b0;
        chk("accept_busy", busy, 1'b1);
        chk("accept_write", mg.mgmt_write, 1'b1);
        chk("accept_err_clr", cfg_err, 1'b0);
        drive(rand_cfg());
    endtask

    task automatic inject_ignore(input int after);
        repeat (after) @(negedge clk);
        #3;
        if (busy) begin
            cfg_k = $urandom;
            cfg_req = 1'b1;
            @(negedge clk);
            #3;
            cfg_req = 1'b0;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #3;
            n++;
        end while (busy && n < budget);
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles, required 0", n);
        end
        chk("cpl_pending", cq.size(), 0);
        chk("wr_pending", wq.size(), 0);
        repeat (3) @(negedge clk);
        #3;
        chk("idle_stays", busy, 1'b0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, cfg_done, 1'b0);
        chk({tag, "_err"}, cfg_err, 1'b0);
        chk({tag, "_write"}, mg.mgmt_write, 1'b0);
        chk({tag, "_addr"}, mg.mgmt_address, 6'd0);
        chk({tag, "_data"}, mg.mgmt_writedata, 32'd0);
    endtask

    initial begin
        cfg_t c;
        int   z[8];
        int   st[8];
        int   lo, hi, gl, n;
        bit   nev;
        s_lo = 0; s_hi = 0;
        z = '{0, 0, 0, 0, 0, 0, 0, 0};

        repeat (3) @(negedge clk);
        #3;
        chk_reset_outs("rst");
        rst = 1'b0;
        @(negedge clk);
        #3;
        chk_reset_outs("post_rst");

        // 148.5 MHz setting, lock drops then returns
        c.mh = 8'd4; c.ml = 8'd4; c.nh = 8'd0; c.nl = 8'd0; c.nb = 1'b1;
        c.ch = 8'd2; c.cl = 8'd1; c.co = 1'b1;
        c.k = 32'd3908420153; c.bw = 4'd6; c.cp = 3'd1;
        start_txn(c, z, -1, 3, NONE, 1'b0);
        wait_idle(2000);

        // stalls on N and START, ignored request with new K mid-flight
        st = '{0, 5, 0, 0, 0, 0, 0, 40};
        start_txn(rand_cfg(), st, -1, 2, NONE, 1'b0);
        inject_ignore(3);
        wait_idle(2000);

        // lock never returns -> timeout
        start_txn(rand_cfg(), z, -3, 0, NONE, 1'b1);
        wait_idle(2000);
        chk("err_sticky", cfg_err, 1'b1);

        // glitch at stability count 200
        start_txn(rand_cfg(), z, -1, 2, 202, 1'b0);
        wait_idle(2000);

        // reset during the M write
        start_txn(rand_cfg(), z, -1, 2, NONE, 1'b0);
        n = 0;
        while (!(mg.mgmt_write && mg.mgmt_address == 6'h04) && n < 20) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk("m_write_seen", mg.mgmt_address, 6'h04);
        rst = 1'b1;
        #1;
        chk("rst_write_drop", mg.mgmt_write, 1'b0);
        chk("rst_busy_drop", busy, 1'b0);
        wq.delete();
        cq.delete();
        repeat (2) @(negedge clk);
        #3;
        rst = 1'b0;
        chk_reset_outs("mid_rst");

        start_txn(rand_cfg(), z, -1, 3, NONE, 1'b0);
        wait_idle(2000);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 8; i++)
                st[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
            lo  = int'($urandom_range(0, 30)) - 3;
            hi  = lo + int'($urandom_range(0, 12));
            gl  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(20, 300)) : NONE;
            nev = ($urandom_range(0, 5) == 0);
            start_txn(rand_cfg(), st, lo, hi, gl, nev);
            if ($urandom_range(0, 1) == 1) inject_ignore(int'($urandom_range(1, 8)));
            wait_idle(2000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not end, %0d checks so far", checks);
        $fatal(1, "watchdog");
    end

endmodule
